qenc_sample_sched: RTL

Sequencing controller for the quadrature position counter. It issues clear and preset commands to the counter and snapshots the signed count at a programmable period. Each snapshot produces a position/delta (velocity) pair, which is buffered in a small FIFO for CPU or DMA readout through the APB register bank. It also flags the cycle on which the count lands exactly on a programmed compare value.

---
 rtl/qenc_sample_sched.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/qenc_sample_sched.sv
// Quadrature counter sequencer: clear/preset strobes, periodic position/delta
// snapshots into a small FIFO, DMA request and compare-hit pulse.
module qenc_sample_sched #(
  parameter int PERIOD_W   = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3,
  parameter int DMA_THRESH = 4
) (
  input  logic                sys_clock,
  input  logic                cpld_rst_out_data,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic                clr_req,
  input  logic                load_req,
  input  logic [31:0]         load_val,
  input  logic [31:0]         plus_cnt,
  output logic                cnt_clr,
  output logic                cnt_load,
  output logic [31:0]         cnt_load_val,
  input  logic                cmp_en,
  input  logic [31:0]         cmp_val,
  output logic                cmp_irq,
  input  logic                pop,
  output logic [31:0]         fifo_pos,
  output logic [31:0]         fifo_delta,
  output logic [FIFO_AW:0]    fifo_level,
  output logic                fifo_empty,
  output logic                ovf,
  input  logic                ovf_clr,
  output logic                dma_req,
  output logic                busy
);

  localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0] LVL_DMA  = (FIFO_AW+1)'(DMA_THRESH);

  typedef enum logic [2:0] {IDLE, PRIME, RUN, CAPTURE, SETTLE} state_t;

  state_t              state, state_nxt;
  logic [PERIOD_W-1:0] timer, timer_nxt;
  logic                settle_cnt, settle_nxt;
  logic [31:0]         prev, last_cnt;
  logic                cmd;

  assign cmd = clr_req | load_req;

  always_ff @(posedge sys_clock or negedge cpld_rst_out_data) begin
    if (!cpld_rst_out_data) begin
      state      <= IDLE;
      timer      <= '0;
      settle_cnt <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      settle_cnt <= settle_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    settle_nxt = settle_cnt;
    unique case (state)
      IDLE: begin
        timer_nxt = '0;
        if (enable) state_nxt = PRIME;
      end
      PRIME: begin
        timer_nxt = '0;
        state_nxt = RUN;
      end
      RUN: begin
        if (timer == period) begin
          timer_nxt = '0;
          state_nxt = CAPTURE;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      CAPTURE: state_nxt = RUN;
      SETTLE: begin
        settle_nxt = 1'b1;
        if (settle_cnt) begin
          settle_nxt = 1'b0;
          state_nxt  = PRIME;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Re-prime after any counter jump so no snapshot delta straddles it.
    if (cmd) begin
      state_nxt  = SETTLE;
      settle_nxt = 1'b0;
      timer_nxt  = '0;
    end
    if (!enable) begin
      state_nxt  = IDLE;
      settle_nxt = 1'b0;
      timer_nxt  = '0;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge sys_clock or negedge cpld_rst_out_data) begin
    if (!cpld_rst_out_data) begin
      cnt_clr      <= 1'b0;
      cnt_load     <= 1'b0;
      cnt_load_val <= '0;
    end else begin
      cnt_clr  <= clr_req;
      cnt_load <= load_req & ~clr_req;
      if (load_req && !clr_req) cnt_load_val <= load_val;
    end
  end

  // Snapshot FIFO
  logic [FIFO_DEPTH-1:0][31:0] mem_pos, mem_delta;
  logic [FIFO_AW-1:0]          wptr, rptr;
  logic                        push_req, full, do_push, do_pop;
  logic [31:0]                 delta;

  assign delta    = plus_cnt - prev;
  assign push_req = (state == CAPTURE) && enable;
  assign full     = (fifo_level == LVL_FULL);
  assign do_pop   = pop && !fifo_empty;
  assign do_push  = push_req && (!full || do_pop);

  always_ff @(posedge sys_clock) begin
    if (do_push) begin
      mem_pos[wptr]   <= plus_cnt;
      mem_delta[wptr] <= delta;
    end
  end

  always_ff @(posedge sys_clock or negedge cpld_rst_out_data) begin
    if (!cpld_rst_out_data) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      ovf        <= 1'b0;
      prev       <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      fifo_level <= fifo_level + 1'b1;
      else if (do_pop && !do_push) fifo_level <= fifo_level - 1'b1;
      if (push_req && full && !do_pop) ovf <= 1'b1;
      else if (ovf_clr)                ovf <= 1'b0;
      if (state == PRIME || state == CAPTURE) prev <= plus_cnt;
    end
  end

  assign fifo_empty = (fifo_level == '0);
  assign fifo_pos   = fifo_empty ? '0 : mem_pos[rptr];
  assign fifo_delta = fifo_empty ? '0 : mem_delta[rptr];
  assign dma_req    = (fifo_level >= LVL_DMA);

  // Edge-detected compare: fires on arrival at cmp_val, not while dwelling.
  always_ff @(posedge sys_clock or negedge cpld_rst_out_data) begin
    if (!cpld_rst_out_data) begin
      last_cnt <= '0;
      cmp_irq  <= 1'b0;
    end else begin
      last_cnt <= plus_cnt;
      cmp_irq  <= cmp_en && (plus_cnt == cmp_val) && (last_cnt != cmp_val);
    end
  end

endmodule
